alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares one combinational ALU (3-bit ALUCtrl, 32-bit signed operands) among NUM_REQ requesters.
//  Round-robin arbitration; valid/ready handshake on request and response sides.
//  Operands and result are registered around the ALU, so the shared ALU sits between two flop stages.
//  Used by multi-cycle units (address gen, MUL helper, debug) that must not own a private ALU.
// PARAMETERS
//  NUM_REQ   2   number of requesters, legal range 2..4
//  DATA_W    32  operand/result width
//  CTRL_W    3   ALU control width
//  ID_W      2   requester index width, must satisfy 2**ID_W >= NUM_REQ
// PORTS
//  clk_i        in   1               clock, all flops rise-edge
//  rst_i        in   1               synchronous active-high reset
//  req_valid_i  in   NUM_REQ         per-requester request valid
//  req_ready_o  out  NUM_REQ         per-requester accept (one-hot or zero)
//  req_data1_i  in   NUM_REQ*DATA_W  operand 1, requester i at [i*DATA_W +: DATA_W]
//  req_data2_i  in   NUM_REQ*DATA_W  operand 2, same packing
//  req_ctrl_i   in   NUM_REQ*CTRL_W  ALU op code, same packing
//  alu_data1_o  out  DATA_W          to ALU data1_i
//  alu_data2_o  out  DATA_W          to ALU data2_i
//  alu_ctrl_o   out  CTRL_W          to ALU ALUCtrl_i
//  alu_data_i   in   DATA_W          from ALU data_o; the ALU Zero_o output is not used
//  rsp_valid_o  out  1               response valid
//  rsp_ready_i  in   1               response accept
//  rsp_id_o     out  ID_W            index of the requester that owns the response
//  rsp_data_o   out  DATA_W          registered ALU result
//  rsp_zero_o   out  1               1 iff rsp_data_o == 0, computed locally
// BEHAVIOUR
//  FSM with states IDLE, EXEC, RESP; one operation in flight at a time.
//  IDLE: grant = first i with req_valid_i[i], searching from rr_ptr upward modulo NUM_REQ.
//   req_ready_o[grant] = 1 combinationally, only in IDLE. On the valid&ready edge, latch
//   data1/data2/ctrl/id and go to EXEC. With no valid request, stay in IDLE.
//  EXEC: alu_*_o drive the latched operands. At the edge, latch alu_data_i into rsp_data_o
//   and go to RESP.
//  RESP: rsp_valid_o = 1. rsp_data_o, rsp_id_o and rsp_zero_o are stable until the handshake.
//   On rsp_valid_o & rsp_ready_i, set rr_ptr = (id+1) mod NUM_REQ and go to IDLE.
//  Latency: accept edge N, rsp_valid_o high in cycle N+2. Peak throughput is 1 op / 3 cycles.
//  alu_*_o hold the last latched operands in every state. They are 0 after reset.
//  Requester rules: once asserted, valid and payload hold until ready. Dropping valid before
//   grant is allowed, and that requester is skipped.
//  Arithmetic is fully delegated to the ALU: no width change, mul truncated to DATA_W.
//  Shift amounts and op codes pass through unmodified. Every CTRL_W code is legal.
//  Simultaneous requests: round-robin order. No requester waits more than NUM_REQ-1 grants.
//  Backpressure: rsp_ready_i low holds RESP indefinitely, and no new grant is issued meanwhile.
//  Reset (any state, any cycle): state=IDLE, rr_ptr=0, req_ready_o follows IDLE grant logic
//   from the next cycle. rsp_valid_o=0, rsp_data_o=0, rsp_id_o=0, rsp_zero_o=1, alu_*_o=0.
//   An in-flight operation is dropped without a response.
// TESTING
//  1 Single op: req0 add 7,-3 ctrl=100 -> ready0 pulse, rsp_valid 2 cycles later, data=4, id=0, zero=0.
//  2 Contention: req0 and req1 both valid after reset -> grant order 0,1,0,1.
//    Req1 payload sub 5,5 -> data=0, zero=1.
//  3 Backpressure: hold rsp_ready_i=0 for 5 cycles -> rsp_valid stays 1 and data is stable.
//    req_ready_o stays 0 throughout; the op completes on ready.
//  4 Ops sweep: mul 0x00010000*0x00010000 -> 0. srai 0x80000000,4 -> 0xF8000000.
//    sll 1,31 -> 0x80000000. xor, and: checked against a reference model.
//  5 Reset mid-op: assert rst_i in EXEC -> next cycle rsp_valid=0, state IDLE, rr_ptr=0.
//    No stale response afterwards.
//  6 Random: 10k random valid/ready/op mix, NUM_REQ=4 -> every accepted op yields exactly one
//    correct rsp with the correct id. Max wait <= 3 grants.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external combinational ALU among NUM_REQ requesters.
// One op in flight: IDLE grants, EXEC drives the ALU from operand flops, RESP holds the registered result.
module alu_share_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 3,
    parameter int ID_W    = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0] req_data1_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data2_i,
    input  logic [NUM_REQ*CTRL_W-1:0] req_ctrl_i,
    output logic [DATA_W-1:0]         alu_data1_o,
    output logic [DATA_W-1:0]         alu_data2_o,
    output logic [CTRL_W-1:0]         alu_ctrl_o,
    input  logic [DATA_W-1:0]         alu_data_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      rsp_zero_o
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t            r_state, w_next;
    logic [ID_W-1:0]   r_rr_ptr, r_id, w_hi_id, w_lo_id, w_grant_id;
    logic              w_hi_vld, w_lo_vld, w_accept;
    logic [DATA_W-1:0] r_data1, r_data2, r_rsp_data, w_data1, w_data2;
    logic [CTRL_W-1:0] r_ctrl, w_ctrl;
    // Lowest valid index at or above the pointer wins; otherwise wrap to the lowest valid index.
    always_comb begin
        w_hi_vld = 1'b0;
        w_hi_id  = '0;
        w_lo_vld = 1'b0;
        w_lo_id  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_i[i]) begin
                w_lo_vld = 1'b1;
                w_lo_id  = ID_W'(i);
                if (ID_W'(i) >= r_rr_ptr) begin
                    w_hi_vld = 1'b1;
                    w_hi_id  = ID_W'(i);
                end
            end
        end
    end
    assign w_grant_id = w_hi_vld ? w_hi_id : w_lo_id;
    assign w_accept   = (r_state == IDLE) && w_lo_vld;
    always_comb begin
        req_ready_o = '0;
        w_data1     = '0;
        w_data2     = '0;
        w_ctrl      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == ID_W'(i)) begin
                req_ready_o[i] = w_accept;
                w_data1        = req_data1_i[i*DATA_W +: DATA_W];
                w_data2        = req_data2_i[i*DATA_W +: DATA_W];
                w_ctrl         = req_ctrl_i[i*CTRL_W +: CTRL_W];
            end
        end
    end
    always_comb begin
        w_next = (r_state == IDLE) ? (w_lo_vld ? EXEC : IDLE) :
                 (r_state == EXEC) ? RESP :
                 (rsp_ready_i ? IDLE : RESP);
    end
    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data1    <= '0;
            r_data2    <= '0;
            r_ctrl     <= '0;
            r_id       <= '0;
            r_rsp_data <= '0;
            r_rr_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_data1 <= w_data1;
                r_data2 <= w_data2;
                r_ctrl  <= w_ctrl;
                r_id    <= w_grant_id;
            end
            if (r_state == EXEC)
                r_rsp_data <= alu_data_i;
            if (r_state == RESP && rsp_ready_i)
                r_rr_ptr <= (r_id == ID_W'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
        end
    end
    assign alu_data1_o = r_data1;
    assign alu_data2_o = r_data2;
    assign alu_ctrl_o  = r_ctrl;
    assign rsp_valid_o = (r_state == RESP);
    assign rsp_id_o    = r_id;
    assign rsp_data_o  = r_rsp_data;
    assign rsp_zero_o  = (r_rsp_data == '0);
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and random checks of the shared-ALU arbiter with a 4-requester instance.
module tb_alu_share_arbiter;
    localparam int N = 4;
    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [N-1:0]  req_valid_i;
    logic [N-1:0]  req_ready_o;
    logic [N*32-1:0] req_data1_i, req_data2_i;
    logic [N*3-1:0]  req_ctrl_i;
    logic [31:0]   alu_data1_o, alu_data2_o, alu_data_i;
    logic [2:0]    alu_ctrl_o;
    logic          rsp_valid_o, rsp_ready_i, rsp_zero_o;
    logic [1:0]    rsp_id_o;
    logic [31:0]   rsp_data_o;
    int n_chk = 0, n_pass = 0;
    alu_share_arbiter #(.NUM_REQ(N), .DATA_W(32), .CTRL_W(3), .ID_W(2)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_data1_i(req_data1_i), .req_data2_i(req_data2_i), .req_ctrl_i(req_ctrl_i),
        .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
        .alu_data_i(alu_data_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
        .rsp_data_o(rsp_data_o), .rsp_zero_o(rsp_zero_o)
    );
    always #5 clk_i = ~clk_i;
    // Bench-side ALU: 0 and, 1 xor, 2 sll, 3 or, 4 add, 5 sub, 6 mul, 7 srai
    function automatic logic [31:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd0:    return a & b;
            3'd1:    return a ^ b;
            3'd2:    return a << b[4:0];
            3'd3:    return a | b;
            3'd4:    return a + b;
            3'd5:    return a - b;
            3'd6:    return a * b;
            default: return 32'($signed(a) >>> b[4:0]);
        endcase
    endfunction
    assign alu_data_i = alu_ref(alu_ctrl_o, alu_data1_o, alu_data2_o);
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask
    task automatic set_req(input int r, input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        req_valid_i[r]         = v;
        req_data1_i[r*32 +: 32] = a;
        req_data2_i[r*32 +: 32] = b;
        req_ctrl_i[r*3 +: 3]    = c;
    endtask
    task automatic do_reset;
        rst_i       = 1'b1;
        req_valid_i = '0;
        rsp_ready_i = 1'b0;
        tick;
        tick;
        rst_i = 1'b0;
    endtask
    task automatic wait_grant(input int r, input string tag);
        int k = 0;
        #1;
        while (req_ready_o == '0 && k < 20) begin
            tick;
            k++;
        end
        chk(tag, 32'(req_ready_o), 32'(1 << r));
    endtask
    task automatic do_op(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                         input logic [31:0] exp, input string tag);
        set_req(r, 1'b1, a, b, c);
        wait_grant(r, {tag, "_grant"});
        tick;
        req_valid_i[r] = 1'b0;
        chk({tag, "_exec_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, "_exec_op1"}, alu_data1_o, a);
        tick;
        chk({tag, "_valid"}, 32'(rsp_valid_o), 32'd1);
        chk({tag, "_data"}, rsp_data_o, exp);
        chk({tag, "_id"}, 32'(rsp_id_o), 32'(r));
        chk({tag, "_zero"}, 32'(rsp_zero_o), 32'(exp == 32'd0));
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
        chk({tag, "_done"}, 32'(rsp_valid_o), 32'd0);
    endtask
    logic        pend, acc [N];
    logic [1:0]  exp_id;
    logic [31:0] exp_data;
    int          waitc [N];
    int          max_wait, n_acc, n_rsp, g;
    initial begin
        req_data1_i = '0;
        req_data2_i = '0;
        req_ctrl_i  = '0;
        do_reset;
        chk("rst_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_data", rsp_data_o, 32'd0);
        chk("rst_id", 32'(rsp_id_o), 32'd0);
        chk("rst_zero", 32'(rsp_zero_o), 32'd1);
        chk("rst_alu1", alu_data1_o, 32'd0);
        chk("rst_alu2", alu_data2_o, 32'd0);
        chk("rst_ctrl", 32'(alu_ctrl_o), 32'd0);
        chk("rst_ready", 32'(req_ready_o), 32'd0);
        do_op(0, 32'd7, 32'hFFFF_FFFD, 3'd4, 32'd4, "t1_add");
        do_reset;
        set_req(0, 1'b1, 32'd7, 32'hFFFF_FFFD, 3'd4);
        set_req(1, 1'b1, 32'd5, 32'd5, 3'd5);
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_grant(k % 2, "t2_rr_grant");
            tick;
            tick;
            chk("t2_id", 32'(rsp_id_o), 32'(k % 2));
            chk("t2_data", rsp_data_o, (k % 2 == 1) ? 32'd0 : 32'd4);
            chk("t2_zero", 32'(rsp_zero_o), 32'(k % 2));
            tick;
        end
        req_valid_i = '0;
        rsp_ready_i = 1'b0;
        set_req(2, 1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd1);
        wait_grant(2, "t3_grant");
        tick;
        req_valid_i[2] = 1'b0;
        set_req(1, 1'b1, 32'h7FFF_FFFF, 32'd1, 3'd4);
        tick;
        for (int k = 0; k < 5; k++) begin
            chk("t3_bp_valid", 32'(rsp_valid_o), 32'd1);
            chk("t3_bp_data", rsp_data_o, 32'hFF00_FF00);
            chk("t3_bp_ready", 32'(req_ready_o), 32'd0);
            tick;
        end
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
        chk("t3_released", 32'(rsp_valid_o), 32'd0);
        wait_grant(1, "t3_next_grant");
        tick;
        req_valid_i[1] = 1'b0;
        tick;
        chk("t3_next_data", rsp_data_o, 32'h8000_0000);
        chk("t3_next_id", 32'(rsp_id_o), 32'd1);
        rsp_ready_i = 1'b1;
        tick;
        rsp_ready_i = 1'b0;
        do_op(0, 32'h0001_0000, 32'h0001_0000, 3'd6, 32'd0, "t4_mul");
        do_op(1, 32'h8000_0000, 32'd4, 3'd7, 32'hF800_0000, "t4_srai");
        do_op(2, 32'd1, 32'd31, 3'd2, 32'h8000_0000, "t4_sll");
        do_op(3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 3'd0, 32'h00F0_00F0, "t4_and");
        do_op(0, 32'h1234_0000, 32'h0000_5678, 3'd3, 32'h1234_5678, "t4_or");
        set_req(3, 1'b1, 32'd1, 32'd2, 3'd4);
        wait_grant(3, "t5_grant");
        tick;
        req_valid_i[3] = 1'b0;
        rst_i = 1'b1;
        tick;
        rst_i = 1'b0;
        chk("t5_valid", 32'(rsp_valid_o), 32'd0);
        chk("t5_data", rsp_data_o, 32'd0);
        chk("t5_zero", 32'(rsp_zero_o), 32'd1);
        chk("t5_alu1", alu_data1_o, 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("t5_stale", 32'(rsp_valid_o), 32'd0);
        end
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'd0, 32'd0, 3'd0);
        #1;
        chk("t5_rr_ptr", 32'(req_ready_o), 32'd1);
        req_valid_i = '0;
        do_reset;
        pend = 1'b0;
        max_wait = 0;
        n_acc = 0;
        n_rsp = 0;
        for (int i = 0; i < N; i++) begin
            acc[i]   = 1'b0;
            waitc[i] = 0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    req_valid_i[i] = 1'b0;
                    acc[i]   = 1'b0;
                    waitc[i] = 0;
                end else if (!req_valid_i[i]) begin
                    if ($urandom_range(0, 3) == 0) set_req(i, 1'b1, $urandom, $urandom, 3'($urandom));
                    waitc[i] = 0;
                end else if ($urandom_range(0, 31) == 0) begin
                    req_valid_i[i] = 1'b0;
                    waitc[i] = 0;
                end
            end
            rsp_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk_i);
            if (req_ready_o != '0) begin
                chk("r_onehot", 32'($countones(req_ready_o)), 32'd1);
                chk("r_ready_no_valid", 32'(req_ready_o & ~req_valid_i), 32'd0);
                chk("r_overlap", 32'(pend), 32'd0);
                g = 0;
                for (int i = 0; i < N; i++) if (req_ready_o[i]) g = i;
                pend     = 1'b1;
                exp_id   = 2'(g);
                exp_data = alu_ref(req_ctrl_i[g*3 +: 3], req_data1_i[g*32 +: 32], req_data2_i[g*32 +: 32]);
                acc[g]   = 1'b1;
                n_acc++;
                for (int j = 0; j < N; j++) begin
                    if (j != g && req_valid_i[j]) begin
                        waitc[j]++;
                        if (waitc[j] > max_wait) max_wait = waitc[j];
                    end
                end
            end
            if (rsp_valid_o && rsp_ready_i) begin
                chk("r_rsp_pend", 32'(pend), 32'd1);
                chk("r_rsp_id", 32'(rsp_id_o), 32'(exp_id));
                chk("r_rsp_data", rsp_data_o, exp_data);
                chk("r_rsp_zero", 32'(rsp_zero_o), 32'(exp_data == 32'd0));
                pend = 1'b0;
                n_rsp++;
            end
            tick;
        end
        req_valid_i = '0;
        rsp_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_i);
            if (rsp_valid_o) begin
                chk("r_drain_id", 32'(rsp_id_o), 32'(exp_id));
                chk("r_drain_data", rsp_data_o, exp_data);
                pend = 1'b0;
                n_rsp++;
            end
            tick;
        end
        chk("r_drain", 32'(pend), 32'd0);
        chk("r_count", 32'(n_rsp), 32'(n_acc));
        chk("r_max_wait", 32'(max_wait <= 3), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
